// File: rtl/calculator_seq.sv
`default_nettype none
// ============================================================================
//  Module   : calculator_seq
//  Purpose  : WIDTH-bit sequential calculator. ADD, SUB and MAX complete in
//             one cycle. MUL is a shift-add multiplier that handles one
//             multiplier bit per cycle. The block also provides an overflow
//             flag, optional saturation, a busy flag and a chain mode that
//             feeds the last result back in as operand A.
//  Revision : 1.0 - initial release
// ============================================================================
module calculator_seq #(
    parameter int WIDTH    = 5,
    parameter int SATURATE = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             input_valid_i,
    input  logic [1:0]       op_i,
    input  logic             chain_i,
    input  logic             calc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] result_o,
    output logic             output_valid_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic SAT_EN = (SATURATE != 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOADED = 2'd1;
    localparam logic [1:0] S_BUSY   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_sel;
    logic [PW-1:0]    prod;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_q;
    logic             overflow_q;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ov;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    prod_next;
    logic [WIDTH-1:0] mul_res;
    logic             mul_ov;
    logic             mul_last;
    logic [WIDTH-1:0] chain_a;

    // Single-cycle ALU for ADD/SUB/MAX, with saturation applied on overflow
    always_comb begin
        sum_ext = {1'b0, op_a} + {1'b0, op_b};
        alu_res = '0;
        alu_ov  = 1'b0;
        case (op_sel)
            OP_ADD: begin
                alu_ov  = sum_ext[WIDTH];
                alu_res = (SAT_EN && alu_ov) ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
            end
            OP_SUB: begin
                alu_ov  = (op_a < op_b);
                alu_res = (SAT_EN && alu_ov) ? {WIDTH{1'b0}} : (op_a - op_b);
            end
            OP_MAX: begin
                alu_ov  = 1'b0;
                alu_res = (op_a > op_b) ? op_a : op_b;
            end
            default: begin
                // MUL goes through the shift-add path instead
                alu_ov  = 1'b0;
                alu_res = '0;
            end
        endcase
    end

    // Shift-add step: add A shifted by the bit position when multiplier bit is set
    always_comb begin
        mcand     = {{WIDTH{1'b0}}, op_a};
        addend    = op_b[cnt] ? (mcand << cnt) : '0;
        prod_next = prod + addend;
        mul_ov    = |prod_next[PW-1:WIDTH];
        mul_res   = (SAT_EN && mul_ov) ? {WIDTH{1'b1}} : prod_next[WIDTH-1:0];
        mul_last  = (cnt == CW'(WIDTH - 1));
    end

    // In chain mode, the current result register becomes operand A
    always_comb begin
        chain_a = chain_i ? result_q : a_i;
    end

    // Control FSM with its operand, product and result registers. Priority is clear > calc > load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= OP_ADD;
            prod       <= '0;
            cnt        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!clear_i && !calc_i && input_valid_i) begin
                        op_a   <= chain_a;
                        op_b   <= b_i;
                        op_sel <= op_i;
                        state  <= S_LOADED;
                    end
                end
                S_LOADED: begin
                    if (clear_i) begin
                        state      <= S_IDLE;
                        overflow_q <= 1'b0;
                    end else if (calc_i) begin
                        if (op_sel == OP_MUL) begin
                            prod  <= '0;
                            cnt   <= '0;
                            state <= S_BUSY;
                        end else begin
                            result_q   <= alu_res;
                            overflow_q <= alu_ov;
                            state      <= S_DONE;
                        end
                    end else if (input_valid_i) begin
                        op_a   <= chain_a;
                        op_b   <= b_i;
                        op_sel <= op_i;
                    end
                end
                S_BUSY: begin
                    if (clear_i) begin
                        // Abort: the result register keeps its prior value
                        state      <= S_IDLE;
                        overflow_q <= 1'b0;
                    end else begin
                        prod <= prod_next;
                        cnt  <= cnt + CW'(1);
                        if (mul_last) begin
                            result_q   <= mul_res;
                            overflow_q <= mul_ov;
                            state      <= S_DONE;
                        end
                    end
                end
                default: begin
                    // DONE: the result is held until it is acknowledged
                    if (clear_i) begin
                        state      <= S_IDLE;
                        overflow_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign result_o       = result_q;
    assign overflow_o     = overflow_q;
    assign output_valid_o = (state == S_DONE);
    assign busy_o         = (state == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_calculator_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calculator_seq
//  Purpose  : Directed self-checking bench for calculator_seq. It runs a
//             wrapping instance and a saturating instance side by side on
//             the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calculator_seq;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] MAX = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] a, b;
    logic [1:0] op;
    logic       iv, chain, calc, clear;

    logic [4:0] r0, r1;
    logic       v0, v1, ov0, ov1, bz0, bz1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    calculator_seq #(.WIDTH(5), .SATURATE(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b), .input_valid_i(iv),
        .op_i(op), .chain_i(chain), .calc_i(calc), .clear_i(clear),
        .result_o(r0), .output_valid_o(v0), .overflow_o(ov0), .busy_o(bz0)
    );

    calculator_seq #(.WIDTH(5), .SATURATE(1)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b), .input_valid_i(iv),
        .op_i(op), .chain_i(chain), .calc_i(calc), .clear_i(clear),
        .result_o(r1), .output_valid_o(v1), .overflow_o(ov1), .busy_o(bz1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] ta, input logic [4:0] tb_v,
                        input logic [1:0] top, input logic tch);
        a = ta; b = tb_v; op = top; chain = tch; iv = 1'b1;
        tick();
        iv = 1'b0; chain = 1'b0;
    endtask

    task automatic do_calc();
        calc = 1'b1;
        tick();
        calc = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a = '0; b = '0; op = ADD; iv = 0; chain = 0; calc = 0; clear = 0;
        #2;
        tests++;
        if ({v0, ov0, bz0, r0, v1, ov1, bz1, r1} !== 16'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0000", {v0, ov0, bz0, r0, v1, ov1, bz1, r1});
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        load(5'd7, 5'd9, ADD, 1'b0);
        tests++;
        if (v0 !== 1'b0) begin fails++; $display("FAIL add_loaded_valid got=%b exp=0", v0); end
        do_calc();
        tests++;
        if ({v0, ov0, r0} !== {1'b1, 1'b0, 5'd16}) begin
            fails++; $display("FAIL add_7_9 got v/ov/r=%b/%b/%0d exp 1/0/16", v0, ov0, r0);
        end
        // DONE ignores new operands and calc
        load(5'd1, 5'd1, SUB, 1'b0);
        do_calc();
        tests++;
        if ({v0, ov0, r0} !== {1'b1, 1'b0, 5'd16}) begin
            fails++; $display("FAIL done_hold got v/ov/r=%b/%b/%0d exp 1/0/16", v0, ov0, r0);
        end
        do_clear();
        tests++;
        if ({v0, ov0, r0} !== {1'b0, 1'b0, 5'd16}) begin
            fails++; $display("FAIL clear_done got v/ov/r=%b/%b/%0d exp 0/0/16", v0, ov0, r0);
        end
        load(5'd20, 5'd15, ADD, 1'b0);
        do_calc();
        tests++;
        if ({v0, ov0, r0} !== {1'b1, 1'b1, 5'd3}) begin
            fails++; $display("FAIL add_wrap got v/ov/r=%b/%b/%0d exp 1/1/3", v0, ov0, r0);
        end
        tests++;
        if ({v1, ov1, r1} !== {1'b1, 1'b1, 5'd31}) begin
            fails++; $display("FAIL add_sat got v/ov/r=%b/%b/%0d exp 1/1/31", v1, ov1, r1);
        end
        do_clear();
    endtask

    task automatic test_sub_max();
        load(5'd3, 5'd5, SUB, 1'b0);
        do_calc();
        tests++;
        if ({v0, ov0, r0} !== {1'b1, 1'b1, 5'd30}) begin
            fails++; $display("FAIL sub_wrap got v/ov/r=%b/%b/%0d exp 1/1/30", v0, ov0, r0);
        end
        tests++;
        if ({v1, ov1, r1} !== {1'b1, 1'b1, 5'd0}) begin
            fails++; $display("FAIL sub_sat got v/ov/r=%b/%b/%0d exp 1/1/0", v1, ov1, r1);
        end
        do_clear();
        load(5'd12, 5'd19, MAX, 1'b0);
        do_calc();
        tests++;
        if ({v0, ov0, r0, v1, ov1, r1} !== {1'b1, 1'b0, 5'd19, 1'b1, 1'b0, 5'd19}) begin
            fails++; $display("FAIL max_12_19 got r=%0d/%0d ov=%b/%b exp 19/19 ov 0/0", r0, r1, ov0, ov1);
        end
        do_clear();
    endtask

    task automatic run_mul(input logic [4:0] ta, input logic [4:0] tb_v,
                           output int edges, output int busy_cycles);
        load(ta, tb_v, MUL, 1'b0);
        do_calc();
        edges = 1;
        busy_cycles = 0;
        while (!v0 && edges < 20) begin
            if (bz0) busy_cycles++;
            tick();
            edges++;
        end
    endtask

    task automatic test_mul();
        int edges, busy_cycles;
        run_mul(5'd6, 5'd5, edges, busy_cycles);
        tests++;
        if (edges != 6 || busy_cycles != 5) begin
            fails++; $display("FAIL mul_timing got edges/busy=%0d/%0d exp 6/5", edges, busy_cycles);
        end
        tests++;
        if ({v0, ov0, bz0, r0, r1} !== {1'b1, 1'b0, 1'b0, 5'd30, 5'd30}) begin
            fails++; $display("FAIL mul_6_5 got v/ov/bz/r/rs=%b/%b/%b/%0d/%0d exp 1/0/0/30/30",
                              v0, ov0, bz0, r0, r1);
        end
        do_clear();
        run_mul(5'd7, 5'd5, edges, busy_cycles);
        tests++;
        if ({v0, ov0, r0} !== {1'b1, 1'b1, 5'd3}) begin
            fails++; $display("FAIL mul_wrap got v/ov/r=%b/%b/%0d exp 1/1/3", v0, ov0, r0);
        end
        tests++;
        if ({v1, ov1, r1} !== {1'b1, 1'b1, 5'd31}) begin
            fails++; $display("FAIL mul_sat got v/ov/r=%b/%b/%0d exp 1/1/31", v1, ov1, r1);
        end
        do_clear();
        run_mul(5'd31, 5'd1, edges, busy_cycles);
        tests++;
        if ({v0, ov0, r0} !== {1'b1, 1'b0, 5'd31}) begin
            fails++; $display("FAIL mul_31_1 got v/ov/r=%b/%b/%0d exp 1/0/31", v0, ov0, r0);
        end
        do_clear();
    endtask

    task automatic test_chain();
        load(5'd4, 5'd4, ADD, 1'b0);
        do_calc();
        tests++;
        if (r0 !== 5'd8) begin fails++; $display("FAIL chain_first got r=%0d exp 8", r0); end
        do_clear();
        load(5'd17, 5'd3, ADD, 1'b1);
        do_calc();
        tests++;
        if ({v0, ov0, r0, r1} !== {1'b1, 1'b0, 5'd11, 5'd11}) begin
            fails++; $display("FAIL chain_add got v/ov/r/rs=%b/%b/%0d/%0d exp 1/0/11/11", v0, ov0, r0, r1);
        end
        do_clear();
    endtask

    task automatic test_clear_busy();
        int seen_valid;
        load(5'd6, 5'd5, MUL, 1'b0);
        do_calc();
        tick();
        tests++;
        if (bz0 !== 1'b1) begin fails++; $display("FAIL busy_before_abort got=%b exp=1", bz0); end
        do_clear();
        tests++;
        if ({bz0, v0, ov0, r0} !== {1'b0, 1'b0, 1'b0, 5'd11}) begin
            fails++; $display("FAIL abort_busy got bz/v/ov/r=%b/%b/%b/%0d exp 0/0/0/11", bz0, v0, ov0, r0);
        end
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (v0 || bz0) seen_valid++;
        end
        tests++;
        if (seen_valid != 0) begin fails++; $display("FAIL abort_no_pulse got=%0d exp=0", seen_valid); end
    endtask

    task automatic test_clear_calc();
        load(5'd2, 5'd3, ADD, 1'b0);
        clear = 1'b1; calc = 1'b1;
        tick();
        clear = 1'b0; calc = 1'b0;
        tests++;
        if ({v0, bz0} !== 2'b00) begin fails++; $display("FAIL clear_calc got v/bz=%b/%b exp 0/0", v0, bz0); end
        do_calc();
        tests++;
        if ({v0, r0} !== {1'b0, 5'd11}) begin
            fails++; $display("FAIL idle_calc got v/r=%b/%0d exp 0/11", v0, r0);
        end
    endtask

    task automatic test_back_to_back();
        load(5'd1, 5'd2, ADD, 1'b0);
        load(5'd10, 5'd3, SUB, 1'b0);
        do_calc();
        tests++;
        if ({v0, ov0, r0} !== {1'b1, 1'b0, 5'd7}) begin
            fails++; $display("FAIL relatch got v/ov/r=%b/%b/%0d exp 1/0/7", v0, ov0, r0);
        end
        do_clear();
    endtask

    task automatic test_reset_mid_done();
        load(5'd20, 5'd15, ADD, 1'b0);
        do_calc();
        tests++;
        if ({v0, ov0, r0} !== {1'b1, 1'b1, 5'd3}) begin
            fails++; $display("FAIL pre_reset got v/ov/r=%b/%b/%0d exp 1/1/3", v0, ov0, r0);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({v0, ov0, bz0, r0, v1, ov1, bz1, r1} !== 16'd0) begin
            fails++; $display("FAIL async_reset got=%h exp=0000", {v0, ov0, bz0, r0, v1, ov1, bz1, r1});
        end
        #3 rst_n = 1'b1;
        tick();
        tests++;
        if ({v0, ov0, bz0, r0} !== 8'd0) begin
            fails++; $display("FAIL after_reset got=%h exp=00", {v0, ov0, bz0, r0});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_max();
        test_mul();
        test_chain();
        test_clear_busy();
        test_clear_calc();
        test_back_to_back();
        test_reset_mid_done();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
